// File: rtl/proto245_tx_arbiter_if.sv
// Requester-side and FIFO-side signals of the proto245s TX arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requesters and FIFO.
interface proto245_tx_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_N   = 4
);
  localparam int unsigned CH_W = $clog2(CH_N);

  logic [CH_N*DATA_W-1:0] ch_data;
  logic [CH_N-1:0]        ch_valid;
  logic [CH_N-1:0]        ch_last;
  logic [CH_N-1:0]        ch_ready;
  logic [CH_N-1:0]        ch_mask;
  logic [DATA_W-1:0]      txfifo_data;
  logic                   txfifo_wr;
  logic                   txfifo_full;
  logic                   busy;
  logic [CH_W-1:0]        cur_ch;

  modport slave (
    input  ch_data, ch_valid, ch_last, ch_mask, txfifo_full,
    output ch_ready, txfifo_data, txfifo_wr, busy, cur_ch
  );

  modport master (
    output ch_data, ch_valid, ch_last, ch_mask, txfifo_full,
    input  ch_ready, txfifo_data, txfifo_wr, busy, cur_ch
  );
endinterface

// File: rtl/proto245_tx_arbiter.sv
// Round-robin arbiter sharing the proto245s TX FIFO write port among CH_N packet streams.
// Each grant emits a header word (HDR_TAG | channel) followed by at most MAX_PKT_LEN data words.
module proto245_tx_arbiter #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       CH_N        = 4,
  parameter int unsigned       MAX_PKT_LEN = 64,
  parameter logic [DATA_W-1:0] HDR_TAG     = 'hA0
) (
  input logic                  fifo_clk,
  input logic                  fifo_rst,
  proto245_tx_arbiter_if.slave bus
);
  localparam int unsigned CH_W  = $clog2(CH_N);
  localparam int unsigned CNT_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CH_N-1:0]   req;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   idx;
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic [CH_N-1:0]   ready;

  // Search upward from the channel after the last grant, wrapping at CH_N.
  always_comb begin
    req       = bus.ch_valid & bus.ch_mask;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int k = 1; k <= int'(CH_N); k++) begin
      idx = CH_W'((int'(last_grant_q) + k) % int'(CH_N));
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int i = 0; i < int'(CH_N); i++) begin
      if (CH_W'(i) == cur_ch_q) begin
        cur_data  = bus.ch_data[i*DATA_W +: DATA_W];
        cur_valid = bus.ch_valid[i];
        cur_last  = bus.ch_last[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wr           = 1'b0;
    wr_data      = '0;
    ready        = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          cur_ch_d = grant_ch;
          state_d  = StHdr;
        end
      end
      StHdr: begin
        if (!bus.txfifo_full) begin
          wr      = 1'b1;
          wr_data = HDR_TAG | DATA_W'(cur_ch_q);
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        ready[cur_ch_q] = !bus.txfifo_full;
        if (cur_valid && !bus.txfifo_full) begin
          wr      = 1'b1;
          wr_data = cur_data;
          cnt_d   = cnt_q + CNT_W'(1);
          // A packet longer than MAX_PKT_LEN is split; the rest re-arbitrates.
          if (cur_last || cnt_q == CntMax) begin
            last_grant_d = cur_ch_q;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Nothing is accepted in the cycle reset is sampled; the partial packet is dropped.
    if (fifo_rst) begin
      wr      = 1'b0;
      wr_data = '0;
      ready   = '0;
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state_q      <= StIdle;
      cur_ch_q     <= '0;
      last_grant_q <= CH_W'(CH_N - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.ch_ready    = ready;
  assign bus.txfifo_wr   = wr;
  assign bus.txfifo_data = wr_data;
  assign bus.busy        = (state_q != StIdle);
  assign bus.cur_ch      = cur_ch_q;
endmodule
